// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in serial-out framed transmitter (start 0, data LSB first, stop 1)
// Ports:
//   Clk     - rising-edge clock
//   reset   - asynchronous active-high reset
//   data_in - WIDTH-bit word, sampled on the accept edge only
//   load    - request to send data_in (accepted when ready)
//   ready   - idle and able to accept a word
//   tx_out  - serial line, idles high
//   busy    - a frame is on the line
//   done    - one-cycle pulse after the stop bit completes
module piso_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    div;
    logic             tc, last;

    // with one clock per bit the divider stays at 0, so tc is always true
    assign tc   = div == DW'(CLKS_PER_BIT - 1);
    assign last = cnt == CW'(WIDTH - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = load ? START : IDLE;
            START: state_nx = tc ? DATA : START;
            DATA:  state_nx = (tc && last) ? STOP : DATA;
            STOP:  state_nx = tc ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decode registered state only, so reset forces them at once
    assign ready  = state == IDLE;
    assign busy   = state != IDLE;
    assign tx_out = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            div   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == STOP && tc;
            div   <= (state == IDLE || tc) ? '0 : div + 1'b1;
            if (state == IDLE && load)
                shreg <= data_in;
            if (state == START && tc)
                cnt <= '0;
            if (state == DATA && tc) begin
                shreg <= shreg >> 1;
                if (!last)
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: self-checking bench for piso_serial_tx (8-bit/4-clock and 4-bit/1-clock instances)
module tb_piso_serial_tx;
    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       load = 1'b0;
    logic       ready, tx_out, busy, done;
    logic [3:0] d1_data = '0;
    logic       d1_load = 1'b0;
    logic       d1_ready, d1_tx, d1_busy, d1_done;
    int         checks = 0;
    int         fails = 0;

    always #5 Clk = ~Clk;

    piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .Clk(Clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    piso_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .Clk(Clk), .reset(reset), .data_in(d1_data), .load(d1_load),
        .ready(d1_ready), .tx_out(d1_tx), .busy(d1_busy), .done(d1_done)
    );

    // expected line level i cycles into a frame: slot 0 start, slots 1..w data LSB first, then stop
    function automatic logic model_bit(input logic [7:0] d, input int w, input int cpb, input int i);
        int s;
        s = i / cpb;
        return (s == 0) ? 1'b0 : (s <= w) ? d[s-1] : 1'b1;
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({tx_out, ready, busy, done} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_async: tx/ready/busy/done=%b expected 1100", {tx_out, ready, busy, done});
        end
        @(negedge Clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            checks++;
            if ({tx_out, ready, busy, done} !== 4'b1100) begin
                fails++;
                $display("FAIL reset_idle[%0d]: tx/ready/busy/done=%b expected 1100", i, {tx_out, ready, busy, done});
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] d);
        int bc, dc;
        bc = 0;
        dc = 0;
        @(negedge Clk);
        load = 1'b1;
        data_in = d;
        @(negedge Clk);
        load = 1'b0;
        data_in = 8'($urandom);
        checks++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL frame_ready_fall: ready=%b expected 0", ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge Clk);
            if (busy) bc++;
            if (done) dc++;
            checks++;
            if (tx_out !== model_bit(d, 8, 4, i)) begin
                fails++;
                $display("FAIL frame_tx d=%h cyc=%0d: got %b expected %b", d, i + 1, tx_out, model_bit(d, 8, 4, i));
            end
        end
        @(negedge Clk);
        checks++;
        if ({done, ready, busy, tx_out} !== 4'b1101) begin
            fails++;
            $display("FAIL frame_done d=%h: done/ready/busy/tx=%b expected 1101", d, {done, ready, busy, tx_out});
        end
        checks++;
        if (bc != 40) begin
            fails++;
            $display("FAIL frame_busy_len d=%h: got %0d expected 40", d, bc);
        end
        checks++;
        if (dc != 0) begin
            fails++;
            $display("FAIL frame_early_done d=%h: got %0d expected 0", d, dc);
        end
        @(negedge Clk);
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_width d=%h: done=%b expected 0", d, done);
        end
    endtask

    task automatic test_ignored_load;
        @(negedge Clk);
        load = 1'b1;
        data_in = 8'h3C;
        @(negedge Clk);
        load = 1'b0;
        for (int i = 0; i < 41; i++) begin
            if (i > 0) @(negedge Clk);
            if (i == 9) begin
                load = 1'b1;
                data_in = 8'hFF;
            end
            if (i == 10) load = 1'b0;
            checks++;
            if (i < 40 && tx_out !== model_bit(8'h3C, 8, 4, i)) begin
                fails++;
                $display("FAIL ignore_tx cyc=%0d: got %b expected %b", i + 1, tx_out, model_bit(8'h3C, 8, 4, i));
            end else if (i == 40 && done !== 1'b1) begin
                fails++;
                $display("FAIL ignore_done: got %b expected 1", done);
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            checks++;
            if ({busy, tx_out} !== 2'b01) begin
                fails++;
                $display("FAIL ignore_no_second[%0d]: busy/tx=%b expected 01", i, {busy, tx_out});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_tx[$];
        logic exp_done[$];
        int   bc;
        bc = 0;
        for (int i = 0; i < 40; i++) begin exp_tx.push_back(model_bit(8'h01, 8, 4, i)); exp_done.push_back(1'b0); end
        exp_tx.push_back(1'b1); exp_done.push_back(1'b1);
        for (int i = 0; i < 40; i++) begin exp_tx.push_back(model_bit(8'h80, 8, 4, i)); exp_done.push_back(1'b0); end
        exp_tx.push_back(1'b1); exp_done.push_back(1'b1);
        @(negedge Clk);
        load = 1'b1;
        data_in = 8'h01;
        @(negedge Clk);
        data_in = 8'h80;
        for (int i = 0; i < 82; i++) begin
            if (i > 0) @(negedge Clk);
            if (i == 41) load = 1'b0;
            if (busy) bc++;
            checks++;
            if (tx_out !== exp_tx[i] || done !== exp_done[i]) begin
                fails++;
                $display("FAIL b2b cyc=%0d: tx/done=%b%b expected %b%b", i + 1, tx_out, done, exp_tx[i], exp_done[i]);
            end
        end
        checks++;
        if (bc != 80) begin
            fails++;
            $display("FAIL b2b_busy: got %0d expected 80", bc);
        end
    endtask

    task automatic test_reset_mid_frame;
        int dc;
        dc = 0;
        @(negedge Clk);
        load = 1'b1;
        data_in = 8'h55;
        @(negedge Clk);
        load = 1'b0;
        repeat (16) @(negedge Clk);
        checks++;
        if (tx_out !== model_bit(8'h55, 8, 4, 16)) begin
            fails++;
            $display("FAIL midrst_pre: tx=%b expected %b", tx_out, model_bit(8'h55, 8, 4, 16));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tx_out, ready, busy, done} !== 4'b1100) begin
            fails++;
            $display("FAIL midrst_async: tx/ready/busy/done=%b expected 1100", {tx_out, ready, busy, done});
        end
        @(negedge Clk);
        reset = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge Clk);
            if (done || busy) dc++;
        end
        checks++;
        if (dc != 0) begin
            fails++;
            $display("FAIL midrst_no_done: got %0d busy/done cycles expected 0", dc);
        end
        test_frame(8'h0F);
    endtask

    task automatic test_cpb1;
        @(negedge Clk);
        d1_load = 1'b1;
        d1_data = 4'b1001;
        @(negedge Clk);
        d1_load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clk);
            checks++;
            if (i < 6 && (d1_tx !== model_bit(8'h09, 4, 1, i) || d1_busy !== 1'b1 || d1_done !== 1'b0)) begin
                fails++;
                $display("FAIL cpb1 cyc=%0d: tx/busy/done=%b%b%b expected %b10", i + 1, d1_tx, d1_busy, d1_done, model_bit(8'h09, 4, 1, i));
            end else if (i == 6 && {d1_done, d1_ready, d1_tx} !== 3'b111) begin
                fails++;
                $display("FAIL cpb1_done: done/ready/tx=%b expected 111", {d1_done, d1_ready, d1_tx});
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge Clk);
            test_frame(8'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_frame(8'hA5);
        test_ignored_load;
        test_back_to_back;
        test_reset_mid_frame;
        test_cpb1;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
